user_ctrl: RTL and testbench



---
 rtl/user_ctrl_pkg.sv | 26 ++
 rtl/user_ctrl_btn_event.sv | 98 +++++++++
 rtl/user_ctrl.sv | 118 +++++++++++
 tb/tb_user_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/user_ctrl_pkg.sv
// rtl/user_ctrl_pkg.sv - shared states, default timing and clamp helper for user_ctrl
package user_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    DONE = ST_DONE
  } state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

  // Bound a one-step result; borrow marks a decrement that went below zero.
  function automatic int unsigned clamp_val(input logic borrow, input int unsigned res,
                                            input int unsigned lo, input int unsigned hi);
    if (borrow || (res < lo)) return lo;
    else if (res > hi) return hi;
    else return res;
  endfunction

endpackage

// File: rtl/user_ctrl_btn_event.sv
// rtl/user_ctrl_btn_event.sv - button synchroniser, debouncer and press-event generator (auto-repeat under USER_CTRL_AUTOREPEAT_EN)
module btn_event
  import user_ctrl_pkg::*;
#(
`ifdef USER_CTRL_AUTOREPEAT_EN
  parameter bit          REPEAT          = 1'b0,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
`endif
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_ni,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_prev_q;
  logic             armed_q, press_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rpt_fire;

  // Synchroniser resets to "pressed" so a button held through reset never looks like a fresh release.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_ni;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it differs from the current one for DEBOUNCE_CYCLES straight cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else if (sync2_q == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      level_q <= sync2_q;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Events stay blocked after reset until the button has genuinely been seen released.
  always_ff @(posedge clk) begin
    if (rst) armed_q <= 1'b0;
    else if (sync2_q && level_q) armed_q <= 1'b1;
  end

`ifdef USER_CTRL_AUTOREPEAT_EN
  if (REPEAT) begin : g_rpt
    logic [31:0] rpt_cnt_q;
    logic        rpt_phase_q;

    // Count held cycles: first repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
    always_ff @(posedge clk) begin
      if (rst || level_q) begin
        rpt_cnt_q   <= '0;
        rpt_phase_q <= 1'b0;
      end else if (rpt_fire) begin
        rpt_cnt_q   <= 32'd1;
        rpt_phase_q <= 1'b1;
      end else begin
        rpt_cnt_q <= rpt_cnt_q + 32'd1;
      end
    end

    assign rpt_fire = !level_q && (rpt_cnt_q == (rpt_phase_q ? REPEAT_PERIOD : REPEAT_DELAY));
  end else begin : g_no_rpt
    assign rpt_fire = 1'b0;
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // Registered one-cycle pulse on a debounced 1->0 transition (or a repeat tick).
  always_ff @(posedge clk) begin
    if (rst) begin
      level_prev_q <= 1'b1;
      press_q      <= 1'b0;
    end else begin
      level_prev_q <= level_q;
      press_q      <= armed_q & ((level_prev_q & ~level_q) | rpt_fire);
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/user_ctrl.sv
// rtl/user_ctrl.sv - front-panel operand controller with checker handshake; USER_CTRL_AUTOREPEAT_EN enables inc/dec auto-repeat
module user_ctrl
  import user_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned MIN_VAL         = 0,
  parameter int unsigned MAX_VAL         = (1 << WIDTH) - 1,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_ni,
  input  logic             dec_ni,
  input  logic             start_ni,
  output logic [WIDTH-1:0] value_o,
  output logic             en_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             valid_i,
  output logic             done_o,
  output logic             abort_o
);

  logic inc_ev, dec_ev, start_ev;

  btn_event #(
`ifdef USER_CTRL_AUTOREPEAT_EN
    .REPEAT(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD),
`endif
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_inc (.clk(clk), .rst(rst), .btn_ni(inc_ni), .press_o(inc_ev));

  btn_event #(
`ifdef USER_CTRL_AUTOREPEAT_EN
    .REPEAT(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD),
`endif
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dec (.clk(clk), .rst(rst), .btn_ni(dec_ni), .press_o(dec_ev));

  btn_event #(
`ifdef USER_CTRL_AUTOREPEAT_EN
    .REPEAT(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD),
`endif
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start (.clk(clk), .rst(rst), .btn_ni(start_ni), .press_o(start_ev));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d, data_q, data_d;
  logic             en_q, en_d, done_q, done_d, abort_q, abort_d;
  logic [WIDTH:0]   inc_sum, dec_sum;

  // One extra bit keeps the step from wrapping before it is clamped.
  assign inc_sum = {1'b0, value_q} + (WIDTH+1)'(1);
  assign dec_sum = {1'b0, value_q} - (WIDTH+1)'(1);

  // Next-state logic: operand stepping in IDLE, handshake in REQ, single done cycle.
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    data_d  = data_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ev) begin
          data_d  = value_q;
          en_d    = 1'b1;
          state_d = REQ;
        end else if (inc_ev && !dec_ev) begin
          value_d = WIDTH'(clamp_val(1'b0, 32'(inc_sum), MIN_VAL, MAX_VAL));
        end else if (dec_ev && !inc_ev) begin
          value_d = WIDTH'(clamp_val(dec_sum[WIDTH], 32'(dec_sum), MIN_VAL, MAX_VAL));
        end
      end
      REQ: begin
        if (valid_i) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else if (start_ev) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          en_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      value_q <= WIDTH'(MIN_VAL);
      data_q  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      data_q  <= data_d;
      en_q    <= en_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign value_o = value_q;
  assign data_o  = data_q;
  assign en_o    = en_q;
  assign done_o  = done_q;
  assign abort_o = abort_q;

endmodule

// File: tb/tb_user_ctrl.sv
// tb/tb_user_ctrl.sv - directed self-checking bench for user_ctrl
module tb_user_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             inc_ni, dec_ni, start_ni, valid_i;
  logic [WIDTH-1:0] value_o, data_o;
  logic             en_o, done_o, abort_o;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  user_ctrl #(
    .WIDTH(WIDTH), .MIN_VAL(2), .MAX_VAL(12), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .rst(rst), .inc_ni(inc_ni), .dec_ni(dec_ni), .start_ni(start_ni),
    .value_o(value_o), .en_o(en_o), .data_o(data_o), .valid_i(valid_i),
    .done_o(done_o), .abort_o(abort_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_o) done_cnt++;
    if (abort_o) abort_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press the selected buttons together for 8 cycles, then release and let them settle.
  task automatic press(input bit do_inc, input bit do_dec, input bit do_start);
    @(posedge clk); #1;
    if (do_inc) inc_ni = 1'b0;
    if (do_dec) dec_ni = 1'b0;
    if (do_start) start_ni = 1'b0;
    cycles(8);
    inc_ni = 1'b1; dec_ni = 1'b1; start_ni = 1'b1;
    cycles(10);
  endtask

  initial begin
    rst = 1'b1; inc_ni = 1'b1; dec_ni = 1'b1; start_ni = 1'b1; valid_i = 1'b0;
    cycles(3);
    chk("rst_value", value_o, 2);
    chk("rst_en", en_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_abort", abort_o, 0);
    rst = 1'b0;
    cycles(5);

    // Three presses with exact latency: no change after 7 edges, +1 after the 8th.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      inc_ni = 1'b0;
      cycles(7);
      chk("lat_before", value_o, 2 + i);
      cycles(1);
      chk("lat_after", value_o, 3 + i);
      inc_ni = 1'b1;
      cycles(10);
    end

    for (int i = 0; i < 15; i++) press(1, 0, 0);
    chk("sat_max", value_o, 12);
    for (int i = 0; i < 15; i++) press(0, 1, 0);
    chk("sat_min", value_o, 2);

    // Bounce every 2 cycles for 20 cycles, then stable low.
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      inc_ni = (i % 2 == 1);
      cycles(2);
    end
    chk("bounce_no_event", value_o, 2);
    inc_ni = 1'b0;
    cycles(8);
    inc_ni = 1'b1;
    cycles(10);
    chk("bounce_one_event", value_o, 3);

    for (int i = 0; i < 4; i++) press(1, 0, 0);
    chk("to_seven", value_o, 7);
    press(1, 1, 0);
    chk("inc_dec_same", value_o, 7);

    // Request, frozen operand, completion.
    @(posedge clk); #1;
    start_ni = 1'b0;
    cycles(7);
    chk("start_en_early", en_o, 0);
    cycles(1);
    chk("start_en", en_o, 1);
    chk("start_data", data_o, 7);
    start_ni = 1'b1;
    cycles(10);
    press(1, 0, 0);
    chk("req_frozen", value_o, 7);
    chk("req_en_held", en_o, 1);
    valid_i = 1'b1;
    cycles(1);
    valid_i = 1'b0;
    chk("valid_done", done_o, 1);
    chk("valid_en_low", en_o, 0);
    cycles(1);
    chk("done_single", done_o, 0);
    press(1, 0, 0);
    chk("idle_after_done", value_o, 8);

    // Abort.
    press(0, 0, 1);
    chk("req2_en", en_o, 1);
    chk("req2_data", data_o, 8);
    @(posedge clk); #1;
    start_ni = 1'b0;
    cycles(8);
    chk("abort_pulse", abort_o, 1);
    chk("abort_en_low", en_o, 0);
    chk("abort_no_done", done_o, 0);
    cycles(1);
    chk("abort_single", abort_o, 0);
    start_ni = 1'b1;
    cycles(10);

    // Valid and start in the same cycle: done wins.
    press(0, 0, 1);
    chk("req3_en", en_o, 1);
    @(posedge clk); #1;
    start_ni = 1'b0;
    cycles(7);
    valid_i = 1'b1;
    cycles(1);
    valid_i = 1'b0;
    chk("race_done", done_o, 1);
    chk("race_no_abort", abort_o, 0);
    chk("race_en_low", en_o, 0);
    start_ni = 1'b1;
    cycles(10);

    // Reset in the middle of a request.
    press(0, 0, 1);
    chk("req4_en", en_o, 1);
    rst = 1'b1;
    cycles(1);
    chk("midrst_en", en_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_abort", abort_o, 0);
    chk("midrst_value", value_o, 2);
    chk("midrst_data", data_o, 0);
    rst = 1'b0;
    cycles(5);

    // Button held through reset produces nothing until released and pressed again.
    inc_ni = 1'b0;
    cycles(2);
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(20);
    chk("held_rst_no_event", value_o, 2);
    inc_ni = 1'b1;
    cycles(12);
    chk("held_rst_release", value_o, 2);
    press(1, 0, 0);
    chk("held_rst_repress", value_o, 3);

    chk("done_count", done_cnt, 2);
    chk("abort_count", abort_cnt, 1);

`ifdef USER_CTRL_AUTOREPEAT_EN
    // Debounced low for 20 cycles: initial + first repeat + three periodic repeats.
    @(posedge clk); #1;
    inc_ni = 1'b0;
    cycles(20);
    inc_ni = 1'b1;
    cycles(15);
    chk("autorepeat", value_o, 8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
